// File: rtl/rgb_mon_pkg.sv
// Shared types and constants for the RGB LCD timing monitor.
// FSM states, CRC-16-CCITT constants and RGB565 word packing.
package rgb_mon_pkg;

    typedef enum logic [1:0] {
        SEEK,
        MEASURE,
        TRACK
    } mon_state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    function automatic logic [15:0] pack565(
        input logic [4:0] r,
        input logic [5:0] g,
        input logic [4:0] b
    );
        return {r, g, b};
    endfunction

endpackage

// File: rtl/rgb_crc16_step.sv
// One-word CRC-16-CCITT update, MSB-first, purely combinational.
// Used by rgb_timing_monitor only when RGB_MONITOR_CRC_EN is defined.
module rgb_crc16_step
    import rgb_mon_pkg::*;
(
    input  logic [15:0] crc,
    input  logic [15:0] data,
    output logic [15:0] crc_next
);

    always_comb begin
        crc_next = crc;
        for (int i = 15; i >= 0; i--) begin
            if (crc_next[15] ^ data[i]) begin
                crc_next = {crc_next[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                crc_next = {crc_next[14:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/rgb_timing_monitor.sv
// Receive-side LCD timing and per-frame pixel checksum monitor.
// Define RGB_MONITOR_CRC_EN to make FRAME_SUM a CRC-16-CCITT instead of a sum.
module rgb_timing_monitor
    import rgb_mon_pkg::*;
#(
    parameter int CW       = 12,
    parameter bit SYNC_POL = 1'b0,
    parameter bit DE_POL   = 1'b1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          LCD_DE,
    input  logic          LCD_HSYNC,
    input  logic          LCD_VSYNC,
    input  logic [4:0]    LCD_R,
    input  logic [5:0]    LCD_G,
    input  logic [4:0]    LCD_B,
    output logic [CW-1:0] H_ACTIVE,
    output logic [CW-1:0] H_TOTAL,
    output logic [CW-1:0] V_ACTIVE,
    output logic [CW-1:0] V_TOTAL,
    output logic [15:0]   FRAME_SUM,
    output logic          FRAME_VALID,
    output logic          LOCKED,
    output logic          ERR_WIDTH
);

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    logic        de_r, hs_r, vs_r;
    logic        de_q, hs_q, vs_q;
    logic [15:0] pix_r, pix_d;
    logic        de_d, de_fall, hs_rise, vs_rise;
    logic        de_a, hs_a, vs_a, de_qa, hs_qa, vs_qa;

    assign de_a  = (de_r == DE_POL);
    assign hs_a  = (hs_r == SYNC_POL);
    assign vs_a  = (vs_r == SYNC_POL);
    assign de_qa = (de_q == DE_POL);
    assign hs_qa = (hs_q == SYNC_POL);
    assign vs_qa = (vs_q == SYNC_POL);

    // Pins -> raw register -> previous copy; edge flags registered once more.
    always_ff @(posedge CLK) begin
        if (RST) begin
            de_r    <= ~DE_POL;
            hs_r    <= ~SYNC_POL;
            vs_r    <= ~SYNC_POL;
            de_q    <= ~DE_POL;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
            pix_r   <= '0;
            pix_d   <= '0;
            de_d    <= 1'b0;
            de_fall <= 1'b0;
            hs_rise <= 1'b0;
            vs_rise <= 1'b0;
        end else begin
            de_r    <= LCD_DE;
            hs_r    <= LCD_HSYNC;
            vs_r    <= LCD_VSYNC;
            de_q    <= de_r;
            hs_q    <= hs_r;
            vs_q    <= vs_r;
            pix_r   <= pack565(LCD_R, LCD_G, LCD_B);
            pix_d   <= pix_r;
            de_d    <= de_a;
            de_fall <= de_qa & ~de_a;
            hs_rise <= hs_a & ~hs_qa;
            vs_rise <= vs_a & ~vs_qa;
        end
    end

    mon_state_t  state;
    logic [CW-1:0] hcnt, htot, vtot, vact, hact, decnt, ref_w;
    logic          ref_v, err;
    logic [15:0]   acc, acc_step;

    logic [CW-1:0] hcnt_n, htot_n, vtot_n, vact_n, hact_n, decnt_n, ref_w_n;
    logic [CW-1:0] cap_w;
    logic          cap_en, ref_v_n, err_n, match;
    logic [15:0]   acc_n;

`ifdef RGB_MONITOR_CRC_EN
    localparam logic [15:0] ACC_INIT = CRC_INIT;
    logic [15:0] crc_nx;

    rgb_crc16_step u_crc (
        .crc      (acc),
        .data     (pix_d),
        .crc_next (crc_nx)
    );

    assign acc_step = crc_nx;
`else
    localparam logic [15:0] ACC_INIT = 16'h0000;

    assign acc_step = acc + pix_d;
`endif

    // Frame totals including this cycle, so a VSYNC edge publishes them directly.
    always_comb begin
        hcnt_n  = hs_rise ? ONE : sat_inc(hcnt);
        htot_n  = hs_rise ? hcnt : htot;
        vtot_n  = hs_rise ? sat_inc(vtot) : vtot;
        decnt_n = de_d ? sat_inc(decnt) : '0;
        cap_en  = (de_fall && (decnt != '0)) || (vs_rise && de_d);
        cap_w   = de_d ? decnt_n : decnt;
        vact_n  = cap_en ? sat_inc(vact) : vact;
        hact_n  = cap_en ? cap_w : hact;
        ref_v_n = ref_v | cap_en;
        ref_w_n = (cap_en && !ref_v) ? cap_w : ref_w;
        err_n   = err | (cap_en && ref_v && (cap_w != ref_w));
        acc_n   = de_d ? acc_step : acc;
        match   = (hact_n == H_ACTIVE) && (htot_n == H_TOTAL) &&
                  (vact_n == V_ACTIVE) && (vtot_n == V_TOTAL) &&
                  !err_n && !ERR_WIDTH;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= SEEK;
            hcnt        <= '0;
            htot        <= '0;
            vtot        <= '0;
            vact        <= '0;
            hact        <= '0;
            decnt       <= '0;
            ref_w       <= '0;
            ref_v       <= 1'b0;
            err         <= 1'b0;
            acc         <= ACC_INIT;
            H_ACTIVE    <= '0;
            H_TOTAL     <= '0;
            V_ACTIVE    <= '0;
            V_TOTAL     <= '0;
            FRAME_SUM   <= '0;
            FRAME_VALID <= 1'b0;
            LOCKED      <= 1'b0;
            ERR_WIDTH   <= 1'b0;
        end else begin
            FRAME_VALID <= 1'b0;
            hcnt        <= hcnt_n;

            unique case (state)
                SEEK:    if (vs_rise) state <= MEASURE;
                MEASURE: if (vs_rise) state <= TRACK;
                default: state <= TRACK;
            endcase

            if (vs_rise) begin
                htot  <= '0;
                vtot  <= '0;
                vact  <= '0;
                hact  <= '0;
                decnt <= '0;
                ref_w <= '0;
                ref_v <= 1'b0;
                err   <= 1'b0;
                acc   <= ACC_INIT;
            end else if (state != SEEK) begin
                htot  <= htot_n;
                vtot  <= vtot_n;
                vact  <= vact_n;
                hact  <= hact_n;
                decnt <= decnt_n;
                ref_w <= ref_w_n;
                ref_v <= ref_v_n;
                err   <= err_n;
                acc   <= acc_n;
            end

            if (vs_rise && (state != SEEK)) begin
                H_ACTIVE    <= hact_n;
                H_TOTAL     <= htot_n;
                V_ACTIVE    <= vact_n;
                V_TOTAL     <= vtot_n;
                FRAME_SUM   <= acc_n;
                ERR_WIDTH   <= err_n;
                LOCKED      <= match;
                FRAME_VALID <= 1'b1;
            end
        end
    end

endmodule

// File: doc/rgb_timing_monitor.md
Name: rgb_timing_monitor

Overview:
Receive-side checker for the parallel RGB LCD interface driven by the panel timing generator. Samples DE/HSYNC/VSYNC/RGB565 in the pixel-clock domain, measures horizontal and vertical timing, and accumulates a per-frame pixel checksum. Results are latched and published once per frame. Used as an on-chip loopback monitor and as a simulation scoreboard for the video path.

Parameters:
CW, 12, width of all timing counters and result ports
SYNC_POL, 0, active level of HSYNC/VSYNC (0 = active-low)
DE_POL, 1, active level of DE

Ports:
CLK  in  1  pixel clock; all logic on rising edge
RST  in  1  synchronous reset, active-high
LCD_DE  in  1  data enable
LCD_HSYNC  in  1  horizontal sync
LCD_VSYNC  in  1  vertical sync
LCD_R  in  5  red
LCD_G  in  6  green
LCD_B  in  5  blue
H_ACTIVE  out  CW  DE-active pixels in the last line of the frame
H_TOTAL  out  CW  clocks between HSYNC assert edges
V_ACTIVE  out  CW  lines containing DE in the frame
V_TOTAL  out  CW  HSYNC assert edges in the frame
FRAME_SUM  out  16  checksum of active pixels in the frame
FRAME_VALID  out  1  one-cycle pulse; result ports updated this cycle
LOCKED  out  1  timing stable across consecutive frames
ERR_WIDTH  out  1  some line's DE width differed from the frame's first DE line

Behaviour:
- Clock/reset: one clock (CLK). RST is synchronous and active-high.
- Input stage: all inputs are registered once; edges are detected as the registered value vs its previous registered copy. Polarity parameters are applied after registering.
- Event timing: a pin event sampled at edge k is an edge event at edge k+1. Results are visible with FRAME_VALID at edge k+2.
- FSM:
  - SEEK: after reset, ignore everything until the first VSYNC assert edge, then go to MEASURE.
  - MEASURE: count the first full frame. The next VSYNC assert edge publishes results and goes to TRACK.
  - TRACK: each VSYNC assert edge publishes results and restarts the counters.
  - No transition out of TRACK except reset.
- Counters (saturate at all-ones, never wrap):
  - hcnt clears on each HSYNC assert edge; its value at that edge loads H_TOTAL.
  - decnt counts DE-active cycles and is captured on the DE deassert edge.
  - The first DE line of a frame sets the reference width. Any later line with a different width sets a frame-local error flag.
  - V_ACTIVE increments on each DE deassert edge. V_TOTAL increments on each HSYNC assert edge.
  - Simultaneous HSYNC and VSYNC assert edges: count the HSYNC edge in the ending frame, then restart.
- Checksum: FRAME_SUM is the sum mod 2^16 of {R,G,B} for every DE-active cycle of the frame.
- Publish (edge FRAME_VALID=1): all results load together, including ERR_WIDTH from the frame-local flag. Ports hold until the next publish.
- LOCKED: set on a publish whose H_ACTIVE/H_TOTAL/V_ACTIVE/V_TOTAL equal the previous publish and ERR_WIDTH=0. Cleared on any publish that fails that test.
- DE still high at a VSYNC edge: capture the partial width as a line and count it in V_ACTIVE.
- Reset values: all result ports 0, FRAME_VALID 0, LOCKED 0, ERR_WIDTH 0, state SEEK. RST mid-frame discards partial counts. The first publish after RST requires one full frame.

Optional Feature:
RGB_MONITOR_CRC_EN
- Defined: FRAME_SUM is CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first, no final xor) over the 16-bit {R,G,B} words.
- Undefined: additive mod-2^16 sum as above; no CRC logic is instantiated.

Decomposition:
- Package rgb_mon_pkg holds:
  - state enum (SEEK, MEASURE, TRACK)
  - CRC polynomial and init constants
  - RGB565 packing function
- One sub-module, rgb_crc16_step: combinational next-CRC from {crc, data16}. Instantiated only under RGB_MONITOR_CRC_EN.

Test Plan:
- Nominal timing: 16 active px, H total 24, 8 active lines, V total 12, constant pixel 0x0001, active-low syncs. Required:
  - first FRAME_VALID two cycles after the second VSYNC assert;
  - H_ACTIVE=16, H_TOTAL=24, V_ACTIVE=8, V_TOTAL=12, FRAME_SUM=0x0080;
  - LOCKED=1 on the second publish.
- Reset/SEEK: RST asserted mid-frame for 3 cycles. Required: all outputs 0, no FRAME_VALID until one complete frame after the next VSYNC edge.
- Width error: line 5 DE shortened to 15 px. Required: ERR_WIDTH=1 and LOCKED=0 for that frame; the next clean frame gives ERR_WIDTH=0; LOCKED=1 a frame later.
- Timing change: H total 24 -> 26 between frames. Required: publish shows H_TOTAL=26, LOCKED falls to 0, and reasserts after the next identical frame.
- Saturation/wrap: pixel 0xFFFF on 16x8. Required:
  - sum mode: FRAME_SUM=0xFF80;
  - with RGB_MONITOR_CRC_EN: FRAME_SUM equals the reference-model CRC.
  - Separately, HSYNC held inactive beyond 2^CW clocks gives H_TOTAL=0xFFF.
- Edge coincidence: HSYNC and VSYNC asserted on the same cycle. Required: V_TOTAL includes that line for the ending frame, and the new frame starts its count at 0.
